icache_fill_ctrl: RTL and testbench
===================================

// Module: icache_fill_ctrl
// PURPOSE
//  Miss/refill controller for the direct-mapped I-cache (64 lines x 64b, tag=addr[15:8], index=addr[7:2], word=addr[1:0]).
//  Detects a fetch miss and stalls the fetch stage.
//  Reads the 4 words of the missing line from instruction memory over a ready-qualified handshake.
//  Assembles the 64b line and writes it into the cache with a single-cycle write pulse, then releases the stall.
// PARAMETERS
//  ADDR_W      16   byte/word address width (16b-word addressed memory)
//  WORD_W      16   instruction word width
//  WORDS       4    words per cache line (line width = WORDS*WORD_W = 64)
//  TIMEOUT_CYC 255  max cycles waiting for mem_rdy on one word before aborting
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   reset, asynchronous, active-low
//  fetch_req      in   1   fetch stage presents a valid fetch_addr this cycle
//  fetch_addr     in   16  instruction address being fetched
//  cache_hit      in   1   cache hit indication for fetch_addr (combinational from cache)
//  stall          out  1   freeze PC/fetch stage
//  cache_we       out  1   cache line write strobe (one cycle per fill)
//  cache_addr     out  16  line base address for the write: {miss_addr[15:2],2'b00}
//  cache_wr_line  out  64  assembled line; word k in bits [16k+15:16k]
//  mem_re         out  1   memory read request
//  mem_addr       out  16  memory word address
//  mem_rdata      in   16  read data, valid when mem_rdy=1
//  mem_rdy        in   1   memory accepts/returns the current request this cycle
//  fill_err       out  1   one-cycle pulse: fill aborted on timeout
// BEHAVIOUR
//  Reset: state=IDLE; stall, cache_we, mem_re, fill_err=0; cache_addr, mem_addr, cache_wr_line, word cnt, timer=0.
//  FSM IDLE -> FILL -> WRITE -> RESUME -> IDLE; FILL -> IDLE on timeout.
//  IDLE: miss = fetch_req & ~cache_hit. stall = miss (combinational in IDLE only).
//   On miss, latch base={fetch_addr[15:2],2'b00}, cnt=0, timer=0; go FILL.
//  FILL: stall=1, mem_re=1, mem_addr=base+cnt.
//   mem_addr is stable until mem_rdy=1 is sampled.
//   On mem_rdy: line[cnt]<=mem_rdata; timer=0; if cnt==WORDS-1 go WRITE, else cnt++.
//   Zero-wait memory => one word per cycle.
//   No mem_rdy: timer++; at timer==TIMEOUT_CYC-1: fill_err=1 for one cycle, go IDLE.
//   An aborted fill produces no cache_we and discards the partial line.
//  WRITE: stall=1, mem_re=0, cache_we=1 exactly one cycle.
//   cache_addr=base and cache_wr_line stay stable this cycle; go RESUME.
//  RESUME: stall=1 one cycle so the cache re-reads the now-valid line (registered instr); go IDLE.
//  Latency: miss detected in cycle T; zero-wait memory gives cache_we in T+5, stall low in T+7.
//   stall is high for 7 cycles T..T+6 (IDLE-comb, 4xFILL, WRITE, RESUME).
//  fetch_req/fetch_addr changes outside IDLE are ignored. cache_hit is ignored outside IDLE.
//  The line under fill is always the one latched at the miss.
//  Refill of the same line on a back-to-back miss is legal. No coalescing.
//  Reset mid-fill: immediate return to IDLE, all outputs low, no cache write, partial data dropped.
//  mem_rdy outside FILL is ignored.
//  Address width: base+cnt never carries out of addr[1:0] (cnt<4). No wrap across lines.
// STRUCTURE
//  Shared package icache_pkg:
//   - fill_state_t enum {IDLE,FILL,WRITE,RESUME}
//   - LINE_W=64, WORD_W=16, WORDS=4, TAG_MSB=15, TAG_LSB=8, IDX_MSB=7, IDX_LSB=2
//   - cache is to import the same constants.
//  One sub-module: icache_line_asm, a WORDS x WORD_W capture register.
//   - Write-enable plus index in; flat line out.
//   - Cleared on rst_n.
//  FSM, counter and timer live in icache_fill_ctrl.
// TESTING
//  1. Hit path: fetch_req=1, cache_hit=1, addr 0x0040 -> stall=0, mem_re=0, cache_we=0 throughout.
//  2. Zero-wait miss at 0x12A7 -> mem_addr 0x12A4..0x12A7 on 4 consecutive cycles.
//     Data A0A0,B1B1,C2C2,D3D3 -> cache_we 1 cycle with cache_addr=0x12A4 and wr_line=0xD3D3_C2C2_B1B1_A0A0.
//     stall high exactly 7 cycles.
//  3. Wait states: mem_rdy low 3 cycles per word on miss at 0x0100.
//     -> mem_addr held per word, 16 FILL cycles, line correct, single cache_we.
//  4. Timeout: mem_rdy stuck 0 -> fill_err pulses once after TIMEOUT_CYC cycles.
//     -> cache_we never asserted, returns to IDLE, stall drops next cycle.
//  5. Reset mid-fill: rst_n low after word 2 of miss at 0x0F08 -> all outputs 0 asynchronously.
//     After release, a new miss at 0x0F08 refetches all 4 words from 0x0F08.
//  6. fetch_addr changed to 0x2000 during FILL of 0x1000 -> line written with cache_addr=0x1000.
//     A new miss for 0x2000 is taken only after RESUME.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared I-cache constants, fill FSM states and address helpers.
// Imported by the fill controller, its line assembler and the cache array.
package icache_pkg;

  localparam int ADDR_W      = 16;
  localparam int WORD_W      = 16;
  localparam int WORDS       = 4;
  localparam int LINE_W      = WORDS * WORD_W;
  localparam int TAG_MSB     = 15;
  localparam int TAG_LSB     = 8;
  localparam int IDX_MSB     = 7;
  localparam int IDX_LSB     = 2;
  localparam int CNT_W       = $clog2(WORDS);
  localparam int TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    RESUME
  } fill_state_t;

  function automatic logic [ADDR_W-1:0] line_base(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:CNT_W], {CNT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_asm.sv
// Capture register that collects the words of one cache line.
// Cleared on reset and at the start of each fill.
import icache_pkg::*;

module icache_line_asm (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [CNT_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [LINE_W-1:0] line
);

  logic [WORD_W-1:0] words_q [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++)
        words_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < WORDS; i++)
        words_q[i] <= '0;
    end else if (we) begin
      words_q[idx] <= wdata;
    end
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < WORDS; i++)
      line[i*WORD_W +: WORD_W] = words_q[i];
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// I-cache miss/refill controller: stalls fetch, reads the missing
// line word by word from instruction memory and writes it back.
import icache_pkg::*;

module icache_fill_ctrl #(
  parameter int TMO = TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  output logic              stall,
  output logic              cache_we,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [LINE_W-1:0] cache_wr_line,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              fill_err
);

  localparam int TW = $clog2(TMO + 1);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TW-1:0]     tmr_q;

  logic miss;
  logic latch;
  logic cap;
  logic cnt_inc;
  logic tmr_clr;
  logic tmr_inc;
  logic last_word;
  logic tmo_hit;

  assign miss      = fetch_req & ~cache_hit;
  assign last_word = (cnt_q == CNT_W'(WORDS - 1));
  assign tmo_hit   = (tmr_q == TW'(TMO - 1));

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    mem_re   = 1'b0;
    cache_we = 1'b0;
    fill_err = 1'b0;
    latch    = 1'b0;
    cap      = 1'b0;
    cnt_inc  = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss) begin
          stall   = 1'b1;
          latch   = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        stall  = 1'b1;
        mem_re = 1'b1;
        if (mem_rdy) begin
          cap     = 1'b1;
          tmr_clr = 1'b1;
          if (last_word)
            state_d = WRITE;
          else
            cnt_inc = 1'b1;
        end else if (tmo_hit) begin
          // abort: partial line is dropped, no write
          fill_err = 1'b1;
          state_d  = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      WRITE: begin
        stall    = 1'b1;
        cache_we = 1'b1;
        state_d  = RESUME;
      end
      RESUME: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        base_q <= line_base(fetch_addr);
        cnt_q  <= '0;
        tmr_q  <= '0;
      end else begin
        if (cnt_inc)
          cnt_q <= cnt_q + 1'b1;
        if (tmr_clr)
          tmr_q <= '0;
        else if (tmr_inc)
          tmr_q <= tmr_q + 1'b1;
      end
    end
  end

  assign mem_addr   = (state_q == FILL)
                    ? {base_q[ADDR_W-1:CNT_W], cnt_q}
                    : '0;
  assign cache_addr = base_q;

  icache_line_asm u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (latch),
    .we    (cap),
    .idx   (cnt_q),
    .wdata (mem_rdata),
    .line  (cache_wr_line)
  );

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios plus random fills
// checked against a transaction-level refill model.
module tb_icache_fill_ctrl;

  localparam int TMO = 255;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        cache_hit;
  logic        stall;
  logic        cache_we;
  logic [15:0] cache_addr;
  logic [63:0] cache_wr_line;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rdy;
  logic        fill_err;

  int checks;
  int failures;
  logic [15:0] seed;

  icache_fill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .cache_hit     (cache_hit),
    .stall         (stall),
    .cache_we      (cache_we),
    .cache_addr    (cache_addr),
    .cache_wr_line (cache_wr_line),
    .mem_re        (mem_re),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_rdy       (mem_rdy),
    .fill_err      (fill_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory contents
  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'h12A4: return 16'hA0A0;
      16'h12A5: return 16'hB1B1;
      16'h12A6: return 16'hC2C2;
      16'h12A7: return 16'hD3D3;
      default:  return (a * 16'h9E37) ^ seed;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_we"}, cache_we, 0);
    chk({tag, "_mre"}, mem_re, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_caddr"}, cache_addr, 0);
    chk({tag, "_line"}, cache_wr_line, 0);
    chk({tag, "_err"}, fill_err, 0);
  endtask

  // One miss transaction. Model: line = 4 consecutive memory words
  // from the line base, one accepted per mem_rdy cycle, then one
  // write cycle and one resume cycle.
  task automatic do_fill(input logic [15:0] addr, input int wmin,
                         input int wmax, input bit tmo, input bit hold,
                         input logic [15:0] nxt, input int rst_after);
    logic [15:0] base;
    logic [63:0] line;
    int k;
    int w;
    int t;
    bit aborted;
    base = {addr[15:2], 2'b00};
    for (int i = 0; i < 4; i++)
      line[16*i +: 16] = memf(base + 16'(i));
    k = 0;
    t = 0;
    aborted = 0;
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_addr = addr;
    cache_hit = 1'b0;
    mem_rdy = 1'($urandom);
    mem_rdata = 16'($urandom);
    #1;
    chk("miss_stall", stall, 1);
    chk("miss_mre", mem_re, 0);
    chk("miss_we", cache_we, 0);
    w = tmo ? 32'h7fff_ffff : $urandom_range(wmax, wmin);
    while (k < 4) begin
      @(negedge clk);
      if (k == rst_after) begin
        rst_n = 1'b0;
        fetch_req = 1'b0;
        mem_rdy = 1'b0;
        #1;
        all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (hold) begin
        fetch_req = 1'b1;
        fetch_addr = nxt;
        cache_hit = 1'b0;
      end else begin
        fetch_req = 1'($urandom);
        fetch_addr = 16'($urandom);
        cache_hit = 1'($urandom);
      end
      mem_rdy = (w == 0);
      #1;
      mem_rdata = mem_rdy ? memf(mem_addr) : 16'($urandom);
      chk("fill_stall", stall, 1);
      chk("fill_mre", mem_re, 1);
      chk("fill_maddr", mem_addr, base + 16'(k));
      chk("fill_we", cache_we, 0);
      chk("fill_err", fill_err, tmo && t == TMO - 1);
      if (mem_rdy) begin
        k++;
        t = 0;
        w = $urandom_range(wmax, wmin);
      end else begin
        w--;
        t++;
        if (t == TMO) begin
          aborted = 1;
          break;
        end
      end
    end
    if (!aborted) begin
      @(negedge clk);
      mem_rdy = 1'($urandom);
      #1;
      chk("wr_stall", stall, 1);
      chk("wr_we", cache_we, 1);
      chk("wr_mre", mem_re, 0);
      chk("wr_caddr", cache_addr, base);
      chk("wr_line", cache_wr_line, line);
      @(negedge clk);
      mem_rdy = 1'($urandom);
      #1;
      chk("res_stall", stall, 1);
      chk("res_we", cache_we, 0);
      chk("res_mre", mem_re, 0);
    end
    if (!hold) begin
      @(negedge clk);
      fetch_req = 1'b0;
      mem_rdy = 1'($urandom);
      #1;
      chk("idle_stall", stall, 0);
      chk("idle_we", cache_we, 0);
      chk("idle_mre", mem_re, 0);
      chk("idle_err", fill_err, 0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    seed = 16'($urandom);
    rst_n = 1'b0;
    fetch_req = 1'b0;
    fetch_addr = '0;
    cache_hit = 1'b0;
    mem_rdata = '0;
    mem_rdy = 1'b0;
    #12;
    all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // hit path
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fetch_req = 1'b1;
      fetch_addr = 16'h0040;
      cache_hit = 1'b1;
      mem_rdy = 1'($urandom);
      #1;
      chk("hit_stall", stall, 0);
      chk("hit_mre", mem_re, 0);
      chk("hit_we", cache_we, 0);
    end

    // zero-wait miss, known data
    do_fill(16'h12A7, 0, 0, 0, 0, 16'h0, -1);
    // three wait states per word
    do_fill(16'h0100, 3, 3, 0, 0, 16'h0, -1);
    // timeout abort, then a clean fill still works
    do_fill(16'h0300, 0, 0, 1, 0, 16'h0, -1);
    do_fill(16'h0302, 0, 1, 0, 0, 16'h0, -1);
    // reset after two words, then full refetch
    do_fill(16'h0F08, 0, 0, 0, 0, 16'h0, 2);
    do_fill(16'h0F08, 0, 0, 0, 0, 16'h0, -1);
    // fetch moves on during the fill: old line written, new miss after
    do_fill(16'h1000, 0, 2, 0, 1, 16'h2000, -1);
    do_fill(16'h2000, 0, 0, 0, 0, 16'h0, -1);
    // back-to-back refill of the same line
    do_fill(16'h4444, 0, 1, 0, 1, 16'h4445, -1);
    do_fill(16'h4445, 0, 1, 0, 0, 16'h0, -1);

    // random fills
    for (int n = 0; n < 20; n++)
      do_fill(16'($urandom), 0, 3, 0, 0, 16'h0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
